// File: rtl/gpio_pkg.sv
// Shared types and defaults for the GPIO input debounce stage.
package gpio_pkg;

    typedef enum logic [1:0] {
        STABLE_LO,
        PEND_HI,
        STABLE_HI,
        PEND_LO
    } db_state_t;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEFAULT_NUM_IN          = 9;

endpackage

// File: rtl/gpio_debounce_if.sv
// Pin-side and GPIO-side signal bundle of the debounce stage.
// Carries sticky_clr/sticky_q only when GPIO_DEBOUNCE_STICKY_EN is defined.
interface gpio_debounce_if #(
    parameter int unsigned NUM_CH = gpio_pkg::DEFAULT_NUM_IN
);

    logic              tick;
    logic [NUM_CH-1:0] in_raw;
    logic [NUM_CH-1:0] db_out;
    logic [NUM_CH-1:0] rise_pulse;
    logic [NUM_CH-1:0] fall_pulse;
`ifdef GPIO_DEBOUNCE_STICKY_EN
    logic [NUM_CH-1:0] sticky_clr;
    logic [NUM_CH-1:0] sticky_q;

    modport master (
        output tick, in_raw, sticky_clr,
        input  db_out, rise_pulse, fall_pulse, sticky_q
    );

    modport slave (
        input  tick, in_raw, sticky_clr,
        output db_out, rise_pulse, fall_pulse, sticky_q
    );
`else
    modport master (
        output tick, in_raw,
        input  db_out, rise_pulse, fall_pulse
    );

    modport slave (
        input  tick, in_raw,
        output db_out, rise_pulse, fall_pulse
    );
`endif

endinterface

// File: rtl/gpio_debounce_ch.sv
// One debounce channel: 2-flop synchroniser, 4-state filter FSM, edge pulses
// and, with GPIO_DEBOUNCE_STICKY_EN defined, a sticky rise flag.
module gpio_debounce_ch
    import gpio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic arst_n,
    input  logic tick,
    input  logic in_raw,
`ifdef GPIO_DEBOUNCE_STICKY_EN
    input  logic sticky_clr,
    output logic sticky_q,
`endif
    output logic db_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    db_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             db_q;
    logic             rise_q;
    logic             fall_q;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= in_raw;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            unique case (state_q)
                STABLE_LO: begin
                    if (sync2_q && tick) begin
                        state_q <= PEND_HI;
                        cnt_q   <= CNT_ONE;
                    end
                end
                PEND_HI: begin
                    // A mismatch aborts the pending change even on non-tick cycles.
                    if (!sync2_q) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                    end else if (tick) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q <= STABLE_HI;
                            cnt_q   <= '0;
                            db_q    <= 1'b1;
                            rise_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end
                STABLE_HI: begin
                    if (!sync2_q && tick) begin
                        state_q <= PEND_LO;
                        cnt_q   <= CNT_ONE;
                    end
                end
                PEND_LO: begin
                    if (sync2_q) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                    end else if (tick) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q <= STABLE_LO;
                            cnt_q   <= '0;
                            db_q    <= 1'b0;
                            fall_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                end
            endcase
        end
    end

`ifdef GPIO_DEBOUNCE_STICKY_EN
    logic sticky_r;

    // Set has priority over clear.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            sticky_r <= 1'b0;
        end else begin
            sticky_r <= rise_q | (sticky_r & ~sticky_clr);
        end
    end

    assign sticky_q = sticky_r;
`endif

    assign db_out     = db_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: rtl/gpio_debounce.sv
// Debounce bank feeding the GPIO in_ports bus: NUM_CH independent channels.
// Optional sticky rise flags are built when GPIO_DEBOUNCE_STICKY_EN is defined.
module gpio_debounce
    import gpio_pkg::*;
#(
    parameter int unsigned NUM_CH          = DEFAULT_NUM_IN,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input logic           clk,
    input logic           arst_n,
    gpio_debounce_if.slave bus
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        gpio_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk        (clk),
            .arst_n     (arst_n),
            .tick       (bus.tick),
            .in_raw     (bus.in_raw[i]),
`ifdef GPIO_DEBOUNCE_STICKY_EN
            .sticky_clr (bus.sticky_clr[i]),
            .sticky_q   (bus.sticky_q[i]),
`endif
            .db_out     (bus.db_out[i]),
            .rise_pulse (bus.rise_pulse[i]),
            .fall_pulse (bus.fall_pulse[i])
        );
    end

endmodule

// File: tb/tb_gpio_debounce.sv
// Bench for gpio_debounce: directed scenarios plus random pins/ticks/resets,
// every cycle compared against a run-length reference model.
module tb_gpio_debounce;
    import gpio_pkg::*;

    localparam int unsigned N = DEFAULT_NUM_IN;
    localparam int unsigned D = DEFAULT_DEBOUNCE_CYCLES;

    logic clk = 1'b0;
    logic arst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   edge_no = 0;

    always #5 clk = ~clk;

    gpio_debounce_if #(.NUM_CH(N)) bus ();

    gpio_debounce #(
        .NUM_CH         (N),
        .DEBOUNCE_CYCLES(D)
    ) u_dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    // Reference: a channel flips once D ticked samples in a row disagree with
    // its current level; any agreeing sample resets the run.
    logic [N-1:0] m_s1, m_s2, m_db, m_rise, m_fall, m_sticky;
    int           m_run [N];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_no, got, exp);
        end
    endtask

    task automatic model_step(input logic rst_n, input logic tk, input logic [N-1:0] din,
                              input logic [N-1:0] clr);
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0; m_sticky = '0;
            for (int c = 0; c < N; c++) m_run[c] = 0;
        end else begin
            m_sticky = m_rise | (m_sticky & ~clr);
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < N; c++) begin
                if (m_s2[c] != m_db[c]) begin
                    if (tk) begin
                        m_run[c]++;
                        if (m_run[c] == int'(D)) begin
                            m_db[c]  = m_s2[c];
                            m_run[c] = 0;
                            if (m_s2[c]) m_rise[c] = 1'b1;
                            else         m_fall[c] = 1'b1;
                        end
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = din;
        end
    endtask

    task automatic step(input logic rst_n, input logic tk, input logic [N-1:0] din,
                        input logic [N-1:0] clr);
        @(negedge clk);
        arst_n     = rst_n;
        bus.tick   = tk;
        bus.in_raw = din;
`ifdef GPIO_DEBOUNCE_STICKY_EN
        bus.sticky_clr = clr;
`endif
        @(posedge clk);
        model_step(rst_n, tk, din, clr);
        edge_no++;
        #1;
        check_eq("db_out", bus.db_out, m_db);
        check_eq("rise_pulse", bus.rise_pulse, m_rise);
        check_eq("fall_pulse", bus.fall_pulse, m_fall);
`ifdef GPIO_DEBOUNCE_STICKY_EN
        check_eq("sticky_q", bus.sticky_q, m_sticky);
`endif
    endtask

    // Runs `len` cycles with fixed pins and tick=1; reports the 1-based cycle
    // at which db_out[ch] first equals lvl and the count of matching pulses.
    task automatic measure(input logic [N-1:0] din, input int ch, input logic lvl, input int len,
                           output int at, output int npulse);
        at = -1;
        npulse = 0;
        for (int k = 1; k <= len; k++) begin
            step(1'b1, 1'b1, din, '0);
            if (at < 0 && bus.db_out[ch] === lvl) at = k;
            if (lvl ? bus.rise_pulse[ch] : bus.fall_pulse[ch]) npulse++;
        end
    endtask

    task automatic reset_low();
        step(1'b0, 1'b1, '0, '0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, '0, '0);
    endtask

    initial begin
        int at, np, nr, nf, first;
        logic [N-1:0] din;
        logic         tk, rst;

        arst_n = 1'b0;
        bus.tick = 1'b0;
        bus.in_raw = '0;
`ifdef GPIO_DEBOUNCE_STICKY_EN
        bus.sticky_clr = '0;
`endif
        for (int c = 0; c < N; c++) m_run[c] = 0;
        m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0; m_sticky = '0;

        // Reset held with all pins high, then re-qualification after release.
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1, '1, '0);
            check_eq("rst_db_zero", bus.db_out, 0);
            check_eq("rst_rise_zero", bus.rise_pulse, 0);
        end
        first = -1;
        nr = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 1'b1, '1, '0);
            if (first < 0 && bus.db_out === '1) first = k;
            if (bus.rise_pulse === '1) nr++;
        end
        check_eq("rel_db_edge", first, D + 2);
        check_eq("rel_rise_cnt", nr, 1);

        // ch0 rise and fall latency.
        reset_low();
        measure(9'h001, 0, 1'b1, 12, at, np);
        check_eq("ch0_rise_edge", at, D + 2);
        check_eq("ch0_rise_cnt", np, 1);
        measure(9'h000, 0, 1'b0, 12, at, np);
        check_eq("ch0_fall_edge", at, D + 2);
        check_eq("ch0_fall_cnt", np, 1);

        // ch3 glitch of D-1 cycles rejected, D cycles accepted.
        nr = 0;
        for (int k = 0; k < D - 1; k++) begin
            step(1'b1, 1'b1, 9'h008, '0);
            nr += int'(bus.rise_pulse[3]) + int'(bus.fall_pulse[3]);
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b1, 9'h000, '0);
            nr += int'(bus.rise_pulse[3]) + int'(bus.fall_pulse[3]);
        end
        check_eq("ch3_glitch_pulses", nr, 0);
        check_eq("ch3_glitch_db", bus.db_out[3], 1'b0);
        nr = 0;
        for (int k = 0; k < D; k++) begin
            step(1'b1, 1'b1, 9'h008, '0);
            nr += int'(bus.rise_pulse[3]);
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b1, 9'h000, '0);
            nr += int'(bus.rise_pulse[3]);
        end
        check_eq("ch3_accept_rise", nr, 1);

        // ch5 chatter for 12 cycles, then held high from cycle 13.
        nr = 0; nf = 0; first = -1;
        for (int k = 1; k <= 30; k++) begin
            din = '0;
            din[5] = (k > 12) ? 1'b1 : logic'(k % 2);
            step(1'b1, 1'b1, din, '0);
            if (bus.rise_pulse[5]) begin
                nr++;
                if (first < 0) first = k;
            end
            if (bus.fall_pulse[5]) nf++;
        end
        check_eq("ch5_rise_cnt", nr, 1);
        check_eq("ch5_fall_cnt", nf, 0);
        check_eq("ch5_rise_edge", first, 13 + D + 1);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, '0, '0);

        // ch1 with a tick every 4th cycle; second pass has a drop between ticks.
        first = -1;
        for (int k = 1; k <= 30; k++) begin
            step(1'b1, (k % 4) == 0, 9'h002, '0);
            if (first < 0 && bus.rise_pulse[1]) first = k;
        end
        check_eq("ch1_tick_rise_edge", first, 16);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, '0, '0);
        first = -1;
        for (int k = 1; k <= 40; k++) begin
            step(1'b1, (k % 4) == 0, (k == 9) ? 9'h000 : 9'h002, '0);
            if (first < 0 && bus.rise_pulse[1]) first = k;
        end
        check_eq("ch1_drop_rise_edge", first, 24);

`ifdef GPIO_DEBOUNCE_STICKY_EN
        // ch2 sticky: clear coinciding with the rise pulse loses to the set.
        reset_low();
        first = 0;
        for (int k = 0; k < 20 && first == 0; k++) begin
            step(1'b1, 1'b1, 9'h004, '0);
            if (bus.rise_pulse[2]) first = 1;
        end
        check_eq("ch2_rise_seen", first, 1);
        step(1'b1, 1'b1, 9'h004, 9'h004);
        check_eq("ch2_sticky_set_wins", bus.sticky_q[2], 1'b1);
        step(1'b1, 1'b1, 9'h004, 9'h004);
        check_eq("ch2_sticky_cleared", bus.sticky_q[2], 1'b0);
`endif

        // ch7 reset while pending with cnt=2; must re-qualify from scratch.
        reset_low();
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 9'h080, '0);
        step(1'b0, 1'b1, 9'h080, '0);
        check_eq("ch7_rst_db", bus.db_out[7], 1'b0);
        measure(9'h080, 7, 1'b1, 12, at, np);
        check_eq("ch7_requal_edge", at, D + 2);
        check_eq("ch7_requal_cnt", np, 1);

        // Random pins, ticks, clears and occasional resets.
        din = '0;
        for (int k = 0; k < 600; k++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 5) == 0) din[c] = ~din[c];
            tk  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) != 0);
            step(rst, tk, din, N'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_debounce.md
Name: gpio_debounce

Overview:
- Input conditioning stage placed directly upstream of the GPIO slot peripheral's input bank.
- Takes raw, asynchronous, bouncy button/switch pins from the board, synchronises them to clk, and filters bounce per channel.
- Drives the clean levels into the GPIO in_ports bus.
- Also produces one-cycle rise/fall pulses per channel for edge-triggered consumers (interrupt logic, counters).

Parameters:
- NUM_CH, 9, number of independent input channels (matches GPIO in_ports width).
- DEBOUNCE_CYCLES, 4, consecutive qualifying samples needed to accept a level change; legal range 2..65535.
- CNT_W, $clog2(DEBOUNCE_CYCLES), counter width; derived, not overridden.

Ports:
- clk  input  1  system clock.
- arst_n  input  1  reset; synchronous, active-low; sampled only on posedge clk.
- tick  input  1  sample strobe; tie high to count raw clk cycles, or drive from a prescaler.
- in_raw  input  NUM_CH  raw asynchronous pin levels.
- db_out  output  NUM_CH  debounced stable level per channel; connects to GPIO in_ports.
- rise_pulse  output  NUM_CH  one-cycle pulse when db_out bit goes 0->1.
- fall_pulse  output  NUM_CH  one-cycle pulse when db_out bit goes 1->0.

Behaviour:
- Reset: when arst_n=0 at a posedge clk, the following all clear to 0 on that edge:
  - sync flops, counters, db_out, rise_pulse, fall_pulse, and (if compiled in) sticky_q.
  - Reset has no asynchronous path.
- Synchroniser: two flops per channel, sync1<=in_raw, sync2<=sync1. Only sync2 is used downstream.
- Per-channel FSM, all transitions on posedge clk:
  - States: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
  - STABLE_LO: if sync2=1 and tick, go to PEND_HI with cnt=1.
  - PEND_HI:
    - If sync2=0 (any cycle, tick or not), return to STABLE_LO with cnt=0.
    - Else if tick and cnt=DEBOUNCE_CYCLES-1, go to STABLE_HI with cnt=0, db_out=1, rise_pulse=1.
    - Else if tick, cnt+1.
  - STABLE_HI and PEND_LO: mirror of the above with polarities swapped; fall_pulse asserts on entry to STABLE_LO.
- Latency with tick=1: a raw step set up before edge E reaches sync2 at E+1 and enters PEND at E+2. db_out changes at edge E+DEBOUNCE_CYCLES+1. With D=4, a step before edge 1 gives db_out at edge 6.
- Glitch rejection: a deviation lasting fewer than DEBOUNCE_CYCLES qualifying samples produces no db_out change and no pulse.
- Pulses are registered, last exactly one cycle, and coincide with the first cycle of the new db_out value. rise_pulse and fall_pulse are never both high on the same channel.
- Counter saturation: cnt never exceeds DEBOUNCE_CYCLES-1; there is no wrap.
- Channels are fully independent. Simultaneous events on different channels are all honoured in the same cycle.
- Reset mid-count: all pending state is discarded and the FSM returns to STABLE_LO. A pin held high through reset is re-qualified after release and produces a rise_pulse.
- tick=0 freezes counting but not mismatch clearing.

Optional Feature:
- Macro: GPIO_DEBOUNCE_STICKY_EN.
- With the macro defined, two extra ports are added:
  - sticky_clr  input  NUM_CH.
  - sticky_q  output  NUM_CH.
- sticky_q bit sets on rise_pulse and clears when sticky_clr bit=1. If set and clear occur in the same cycle, set wins. Reset value is 0.
- Without the macro, the ports and flops are absent and behaviour is otherwise identical.

Decomposition:
- gpio_pkg holds:
  - enum db_state_t {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO} (2-bit).
  - localparam DEFAULT_DEBOUNCE_CYCLES=4.
  - localparam DEFAULT_NUM_IN=9.
- Sub-module gpio_debounce_ch: one channel (synchroniser, FSM, counter, pulse flops, optional sticky bit). The top level instantiates NUM_CH copies in a generate loop.

Test Plan:
- Hold arst_n=0 for 3 cycles with in_raw=9'h1FF -> all outputs 0 during reset. After release, db_out=9'h1FF at release edge+D+1 (D=4), and rise_pulse=9'h1FF for exactly that one cycle.
- D=4, tick=1, ch0 0->1 before edge 1 -> db_out[0]=1 at edge 6 and rise_pulse[0]=1 only at edge 6. Later 1->0 gives fall_pulse[0] after the same latency.
- ch3 high pulse of 3 cycles (D=4) -> db_out[3] stays 0 and no pulses; a 4-cycle pulse (as seen at sync2) -> accepted.
- ch5 toggles every cycle for 12 cycles then holds 1 -> exactly one rise_pulse, D+1 edges after the final transition; no fall_pulse.
- tick high every 4th cycle, D=4, ch1 steps high -> db_out[1] rises on the 4th qualifying tick after sync2 goes high. A 1-cycle drop between ticks resets the count.
- GPIO_DEBOUNCE_STICKY_EN: ch2 rise with sticky_clr[2]=1 in the same cycle -> sticky_q[2]=1. Next cycle with sticky_clr[2]=1 -> sticky_q[2]=0. arst_n=0 mid-count on ch7 (cnt=2) -> db_out[7]=0 and the count restarts from 0.
